music_sequencer: RTL and testbench

//  Plays a song stored in the synchronous music ROM. Steps the ROM address at a programmable tempo,

---
 rtl/music_pkg.sv | 21 ++
 rtl/music_sequencer_step_timer.sv | 33 +++
 rtl/music_sequencer.sv | 151 +++++++++++++++
 tb/tb_music_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared constants for the music sequencer: FSM state codes, note rest code, width defaults.
package music_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_NOTE_W = 8;
    localparam int NOTE_REST  = 0;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LATCH = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_PAUSE = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    function automatic logic is_play_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_LATCH) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/music_sequencer_step_timer.sv
// Loadable down-counter holding the remaining ticks of a step; stops at zero.
// Latency: count/flags registered, update one clk after clr/load/en.
// Backpressure: en low freezes the count (pause); clr beats load beats en.
module step_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             zero,
    output logic             last
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);
    assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/music_sequencer.sv
// Steps the music ROM at a programmable tempo and drives the tone generator; ARTIC_GAP_EN adds a note-off gap.
// Latency: one step = STEP_TICKS>>tempo_sel clk (FETCH + LATCH + HOLD); note lags rom_addr by 2 clk.
// Backpressure: pause freezes address, note register and step timer; stop > pause > play.
module music_sequencer
    import music_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int NOTE_W     = DEF_NOTE_W,
    parameter int STEP_TICKS = 2**22,
    parameter int LAST_ADDR  = 240,
    parameter int GAP_TICKS  = 2**19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              play,
    input  logic              pause,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [1:0]        tempo_sel,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [NOTE_W-1:0] rom_note,
    output logic [NOTE_W-1:0] note,
    output logic              playing,
    output logic              song_done
);

    localparam int CNT_W = $clog2(STEP_TICKS + 1);

`ifdef ARTIC_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    state_t            state;
    state_t            saved_state;
    logic [ADDR_W-1:0] addr;
    logic [NOTE_W-1:0] note_r;
    logic              done_pulse;

    logic              tmr_clr;
    logic              tmr_load;
    logic              tmr_en;
    logic [CNT_W-1:0]  tmr_load_val;
    logic [CNT_W-1:0]  tmr_cnt;
    logic              tmr_zero;
    logic              tmr_last;

    logic [31:0]       step_full;
    logic              in_play;
    logic              pause_act;
    logic              term;
    logic              hold_end;
    logic              at_last;
    logic              end_song;
    logic              gap_mute;

    assign in_play   = is_play_state(state);
    assign pause_act = pause && in_play;
    assign term      = (rom_note == NOTE_W'(NOTE_REST)) && (addr != '0);
    assign hold_end  = tmr_last || tmr_zero;
    assign at_last   = (addr == ADDR_W'(LAST_ADDR));
    assign end_song  = !stop && !pause_act &&
                       (((state == ST_LATCH) && term) ||
                        ((state == ST_HOLD) && hold_end && at_last));

    // LATCH and FETCH take two cycles of the step, so HOLD gets the rest (at least one cycle).
    assign step_full    = 32'(STEP_TICKS) >> tempo_sel;
    assign tmr_load_val = (step_full > 32'd2) ? CNT_W'(step_full - 32'd2) : CNT_W'(1);

    assign tmr_clr  = stop;
    assign tmr_load = !stop && !pause_act && (state == ST_LATCH) && !term;
    assign tmr_en   = !stop && !pause_act && (state == ST_HOLD);

    step_timer #(
        .CNT_W (CNT_W)
    ) u_step_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (tmr_clr),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .cnt      (tmr_cnt),
        .zero     (tmr_zero),
        .last     (tmr_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            saved_state <= ST_IDLE;
            addr        <= '0;
            note_r      <= '0;
            done_pulse  <= 1'b0;
        end else begin
            done_pulse <= end_song;
            if (stop) begin
                state  <= ST_IDLE;
                addr   <= '0;
                note_r <= '0;
            end else if (pause_act) begin
                saved_state <= state;
                state       <= ST_PAUSE;
            end else if (end_song) begin
                note_r <= '0;
                if (loop_en) begin
                    addr  <= '0;
                    state <= ST_FETCH;
                end else begin
                    state <= ST_DONE;
                end
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (play) begin
                            addr   <= '0;
                            note_r <= '0;
                            state  <= ST_FETCH;
                        end
                    end
                    ST_FETCH: state <= ST_LATCH;
                    ST_LATCH: begin
                        note_r <= rom_note;
                        state  <= ST_HOLD;
                    end
                    ST_HOLD: begin
                        if (hold_end) begin
                            addr  <= addr + ADDR_W'(1);
                            state <= ST_FETCH;
                        end
                    end
                    ST_PAUSE: begin
                        if (play && !pause) begin
                            state <= saved_state;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // The gap only masks the output so the next step still sees the held note value.
    assign gap_mute  = GAP_EN && (state == ST_HOLD) && (tmr_cnt <= CNT_W'(GAP_TICKS));
    assign note      = ((state == ST_PAUSE) || gap_mute) ? '0 : note_r;
    assign rom_addr  = addr;
    assign playing   = in_play;
    assign song_done = done_pulse;

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer with STEP_TICKS=16, LAST_ADDR=5, GAP_TICKS=1 and a 1-clk ROM model.
module tb_music_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       play, pause, stop, loop_en;
    logic [1:0] tempo_sel;
    logic [7:0] rom_addr;
    logic [7:0] rom_note;
    logic [7:0] note;
    logic       playing;
    logic       song_done;

    logic [7:0] rom [0:255];
    int errors = 0;
    int checks = 0;
    int cyc = 0;

`ifdef ARTIC_GAP_EN
    localparam logic [7:0] GAP_NOTE = 8'h00;
`else
    localparam logic [7:0] GAP_NOTE = 8'h40;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) rom_note <= rom[rom_addr];

    music_sequencer #(
        .ADDR_W     (8),
        .NOTE_W     (8),
        .STEP_TICKS (16),
        .LAST_ADDR  (5),
        .GAP_TICKS  (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .play      (play),
        .pause     (pause),
        .stop      (stop),
        .loop_en   (loop_en),
        .tempo_sel (tempo_sel),
        .rom_addr  (rom_addr),
        .rom_note  (rom_note),
        .note      (note),
        .playing   (playing),
        .song_done (song_done)
    );

    task automatic adv_to(input int n);
        while (cyc < n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic start_play();
        play = 1'b1;
        @(negedge clk);
        play = 1'b0;
        cyc = 0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic load_rom(input logic [7:0] a0, a1, a2, a3, a4, a5);
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rom[0] = a0; rom[1] = a1; rom[2] = a2; rom[3] = a3; rom[4] = a4; rom[5] = a5;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rom_addr !== 8'd0) begin errors++; $display("FAIL reset_addr got=%0d want=0", rom_addr); end
        checks++; if (note !== 8'd0) begin errors++; $display("FAIL reset_note got=%0h want=0", note); end
        checks++; if (playing !== 1'b0) begin errors++; $display("FAIL reset_playing got=%b want=0", playing); end
        checks++; if (song_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", song_done); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_play();
        load_rom(8'h00, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25);
        loop_en = 1'b0;
        start_play();
        checks++; if (playing !== 1'b1) begin errors++; $display("FAIL play_playing got=%b want=1", playing); end
        adv_to(2);
        checks++; if (note !== 8'h00 || song_done !== 1'b0) begin errors++; $display("FAIL play_silent_first note=%0h done=%b want 0/0", note, song_done); end
        for (int k = 1; k <= 5; k++) begin
            adv_to(16 * k);
            checks++; if (rom_addr !== 8'(k)) begin errors++; $display("FAIL play_addr k=%0d got=%0d want=%0d", k, rom_addr, k); end
            adv_to(16 * k + 1);
            checks++; if (note !== rom[k-1]) begin errors++; $display("FAIL play_note_lag k=%0d got=%0h want=%0h", k, note, rom[k-1]); end
            adv_to(16 * k + 2);
            checks++; if (note !== rom[k]) begin errors++; $display("FAIL play_note k=%0d got=%0h want=%0h", k, note, rom[k]); end
        end
        adv_to(95);
        checks++; if (song_done !== 1'b0 || playing !== 1'b1) begin errors++; $display("FAIL play_pre_end done=%b playing=%b want 0/1", song_done, playing); end
        adv_to(96);
        checks++; if (song_done !== 1'b1) begin errors++; $display("FAIL play_end_done got=%b want=1", song_done); end
        checks++; if (playing !== 1'b0 || note !== 8'h00) begin errors++; $display("FAIL play_end_state playing=%b note=%0h want 0/0", playing, note); end
        checks++; if (rom_addr !== 8'd5) begin errors++; $display("FAIL play_end_addr got=%0d want=5", rom_addr); end
        adv_to(97);
        checks++; if (song_done !== 1'b0) begin errors++; $display("FAIL play_done_width got=%b want=0", song_done); end
    endtask

    task automatic test_terminator();
        load_rom(8'h10, 8'h20, 8'h30, 8'h00, 8'h50, 8'h60);
        start_play();
        adv_to(49);
        checks++; if (note !== 8'h30 || song_done !== 1'b0) begin errors++; $display("FAIL term_pre note=%0h done=%b want 30/0", note, song_done); end
        adv_to(50);
        checks++; if (song_done !== 1'b1) begin errors++; $display("FAIL term_done got=%b want=1", song_done); end
        checks++; if (note !== 8'h00 || playing !== 1'b0) begin errors++; $display("FAIL term_state note=%0h playing=%b want 0/0", note, playing); end
        checks++; if (rom_addr !== 8'd3) begin errors++; $display("FAIL term_addr got=%0d want=3", rom_addr); end
        adv_to(60);
        checks++; if (song_done !== 1'b0 || rom_addr !== 8'd3) begin errors++; $display("FAIL term_after done=%b addr=%0d want 0/3", song_done, rom_addr); end
    endtask

    task automatic test_loop();
        load_rom(8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36);
        loop_en = 1'b1;
        start_play();
        adv_to(96);
        checks++; if (song_done !== 1'b1) begin errors++; $display("FAIL loop_done got=%b want=1", song_done); end
        checks++; if (rom_addr !== 8'd0 || playing !== 1'b1 || note !== 8'h00) begin errors++; $display("FAIL loop_restart addr=%0d playing=%b note=%0h want 0/1/0", rom_addr, playing, note); end
        adv_to(97);
        checks++; if (song_done !== 1'b0) begin errors++; $display("FAIL loop_done_width got=%b want=0", song_done); end
        adv_to(98);
        checks++; if (note !== 8'h31) begin errors++; $display("FAIL loop_note got=%0h want=31", note); end
        adv_to(112);
        checks++; if (rom_addr !== 8'd1) begin errors++; $display("FAIL loop_continue got=%0d want=1", rom_addr); end
        loop_en = 1'b0;
        pulse_stop();
    endtask

    task automatic test_pause();
        start_play();
        adv_to(5);
        checks++; if (note !== 8'h31) begin errors++; $display("FAIL pause_pre_note got=%0h want=31", note); end
        pause = 1'b1;
        adv_to(6);
        pause = 1'b0;
        checks++; if (note !== 8'h00 || playing !== 1'b0) begin errors++; $display("FAIL pause_mute note=%0h playing=%b want 0/0", note, playing); end
        adv_to(25);
        checks++; if (note !== 8'h00 || rom_addr !== 8'd0) begin errors++; $display("FAIL pause_frozen note=%0h addr=%0d want 0/0", note, rom_addr); end
        play = 1'b1;
        adv_to(26);
        play = 1'b0;
        checks++; if (note !== 8'h31 || playing !== 1'b1) begin errors++; $display("FAIL pause_resume note=%0h playing=%b want 31/1", note, playing); end
        adv_to(36);
        checks++; if (rom_addr !== 8'd0) begin errors++; $display("FAIL pause_remaining_early got=%0d want=0", rom_addr); end
        adv_to(37);
        checks++; if (rom_addr !== 8'd1) begin errors++; $display("FAIL pause_remaining_step got=%0d want=1", rom_addr); end
        pulse_stop();
    endtask

    task automatic test_tempo_stop();
        tempo_sel = 2'd0;
        start_play();
        adv_to(5);
        tempo_sel = 2'd2;
        adv_to(15);
        checks++; if (rom_addr !== 8'd0) begin errors++; $display("FAIL tempo_midstep got=%0d want=0", rom_addr); end
        adv_to(16);
        checks++; if (rom_addr !== 8'd1) begin errors++; $display("FAIL tempo_step0 got=%0d want=1", rom_addr); end
        adv_to(19);
        checks++; if (rom_addr !== 8'd1) begin errors++; $display("FAIL tempo_step1_early got=%0d want=1", rom_addr); end
        adv_to(20);
        checks++; if (rom_addr !== 8'd2) begin errors++; $display("FAIL tempo_step1 got=%0d want=2", rom_addr); end
        adv_to(24);
        checks++; if (rom_addr !== 8'd3) begin errors++; $display("FAIL tempo_step2 got=%0d want=3", rom_addr); end
        stop = 1'b1;
        play = 1'b1;
        adv_to(25);
        stop = 1'b0;
        play = 1'b0;
        checks++; if (playing !== 1'b0 || rom_addr !== 8'd0 || note !== 8'h00) begin errors++; $display("FAIL stop_state playing=%b addr=%0d note=%0h want 0/0/0", playing, rom_addr, note); end
        checks++; if (song_done !== 1'b0) begin errors++; $display("FAIL stop_no_done got=%b want=0", song_done); end
        adv_to(27);
        checks++; if (playing !== 1'b0 || song_done !== 1'b0) begin errors++; $display("FAIL stop_stays_idle playing=%b done=%b want 0/0", playing, song_done); end
        tempo_sel = 2'd0;
    endtask

    task automatic test_gap();
        load_rom(8'h40, 8'h40, 8'h50, 8'h51, 8'h52, 8'h53);
        start_play();
        adv_to(14);
        checks++; if (note !== 8'h40) begin errors++; $display("FAIL gap_hold got=%0h want=40", note); end
        adv_to(15);
        checks++; if (note !== GAP_NOTE) begin errors++; $display("FAIL gap_step0_end got=%0h want=%0h", note, GAP_NOTE); end
        adv_to(16);
        checks++; if (note !== 8'h40) begin errors++; $display("FAIL gap_fetch got=%0h want=40", note); end
        adv_to(18);
        checks++; if (note !== 8'h40) begin errors++; $display("FAIL gap_repeat got=%0h want=40", note); end
        adv_to(31);
        checks++; if (note !== GAP_NOTE) begin errors++; $display("FAIL gap_step1_end got=%0h want=%0h", note, GAP_NOTE); end
        adv_to(34);
        checks++; if (note !== 8'h50) begin errors++; $display("FAIL gap_next got=%0h want=50", note); end
        pulse_stop();
    endtask

    initial begin
        rst_n = 1'b0; play = 1'b0; pause = 1'b0; stop = 1'b0; loop_en = 1'b0; tempo_sel = 2'd0;
        load_rom(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        test_reset();
        test_play();
        test_terminator();
        test_loop();
        test_pause();
        test_tempo_stop();
        test_gap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
